// File: rtl/bloke2_arbiter.sv
// bloke2_arbiter: time-shares one bloke2b hash core between NREQ byte-stream
// requesters, one whole message at a time. Round-robin grant, core start
// sequencing, message feed from the owner, digest pass-through with a one-hot
// destination tag, plus sticky length/timeout error flags.

// Per-requester slice: gates the requester stream onto the shared core bus
// when this lane owns the core and the arbiter is feeding.
module bloke2_arb_lane (
  input  logic       sel,
  input  logic       feed,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_end,
  input  logic       core_din_ready,
  output logic [7:0] sel_data,
  output logic       sel_valid,
  output logic       sel_end,
  output logic       s_ready
);
  logic act;

  assign act       = sel & feed;
  assign sel_data  = s_data & {8{act}};
  assign sel_valid = s_valid & act;
  assign sel_end   = s_end & act;
  assign s_ready   = core_din_ready & act;
endmodule

module bloke2_arbiter #(
  parameter int NREQ    = 4,
  parameter int DLEN    = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_finish,
  output logic [NREQ-1:0]   grant,
  input  logic [8*NREQ-1:0] s_data,
  input  logic [NREQ-1:0]   s_valid,
  output logic [NREQ-1:0]   s_ready,
  input  logic [NREQ-1:0]   s_end,
  output logic [7:0]        m_data,
  output logic              m_valid,
  output logic              m_end,
  output logic [NREQ-1:0]   m_dest,
  output logic              core_start,
  output logic              core_finish,
  output logic [7:0]        core_din,
  output logic              core_din_valid,
  input  logic              core_din_ready,
  output logic              core_din_end,
  input  logic [7:0]        core_dout,
  input  logic              core_dout_valid,
  input  logic              core_dout_end,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, FEED, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [NREQ-1:0]             grant_q;
  logic [PW-1:0]               own_q, ptr_q, ptr_nxt;
  logic                        fin_q;
  logic [7:0]                  byte_cnt;
  logic [TW-1:0]               to_cnt;
  logic                        err_len_q, err_to_q;

  logic                        win_found;
  logic [PW-1:0]               win_idx;
  logic [NREQ-1:0]             win_oh;

  logic                        feed, drain;
  logic                        din_last, dout_done, to_hit;

  logic [NREQ-1:0][7:0]        ln_data;
  logic [NREQ-1:0]             ln_valid, ln_end;

  assign feed  = (state == FEED);
  assign drain = (state == DRAIN);

  // Round-robin pick: first asserted req scanning from ptr upward, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
          win_found = 1'b1;
          win_idx   = PW'(i);
          win_oh[i] = 1'b1;
        end
      end
    end
  end

  assign ptr_nxt = (own_q == PW'(NREQ - 1)) ? '0 : own_q + 1'b1;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    bloke2_arb_lane u_lane (
      .sel            (grant_q[i]),
      .feed           (feed),
      .s_data         (s_data[8*i +: 8]),
      .s_valid        (s_valid[i]),
      .s_end          (s_end[i]),
      .core_din_ready (core_din_ready),
      .sel_data       (ln_data[i]),
      .sel_valid      (ln_valid[i]),
      .sel_end        (ln_end[i]),
      .s_ready        (s_ready[i])
    );
  end

  // Lanes are gated by a one-hot grant, so an OR-reduce is the owner mux.
  always_comb begin
    core_din       = '0;
    core_din_valid = 1'b0;
    core_din_end   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      core_din       = core_din | ln_data[i];
      core_din_valid = core_din_valid | ln_valid[i];
      core_din_end   = core_din_end | ln_end[i];
    end
  end

  assign din_last  = core_din_valid & core_din_ready & core_din_end;
  assign dout_done = drain & core_dout_valid & core_dout_end;
  assign to_hit    = drain & ~core_dout_valid & (to_cnt == TW'(TIMEOUT - 1));

  // Transaction sequencing: grant, one start pulse, feed message, drain digest.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = START;
      START:   state_nxt = FEED;
      FEED:    if (din_last) state_nxt = DRAIN;
      DRAIN:   if (dout_done || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ownership: latch winner and its finish flag, release and rotate on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      fin_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (win_found) begin
        grant_q <= win_oh;
        own_q   <= win_idx;
        fin_q   <= |(req_finish & win_oh);
      end
    end else if (dout_done || to_hit) begin
      grant_q <= '0;
      fin_q   <= 1'b0;
      ptr_q   <= ptr_nxt;
    end
  end

  // Digest byte count and drain watchdog; both restart with each transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      to_cnt   <= '0;
    end else if (state == START) begin
      byte_cnt <= '0;
      to_cnt   <= '0;
    end else if (drain) begin
      if (core_dout_valid) begin
        byte_cnt <= byte_cnt + 8'd1;
        to_cnt   <= '0;
      end else begin
        to_cnt   <= to_cnt + 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      if (feed && core_dout_valid) err_len_q <= 1'b1;
      if (dout_done && (({1'b0, byte_cnt} + 9'd1) != 9'(DLEN))) err_len_q <= 1'b1;
      if (to_hit) err_to_q <= 1'b1;
    end
  end

  assign grant       = grant_q;
  assign core_finish = fin_q;
  assign core_start  = (state == START);
  assign busy        = (state != IDLE);
  assign m_data      = drain ? core_dout : 8'h00;
  assign m_valid     = drain & core_dout_valid;
  assign m_end       = drain & core_dout_end;
  assign m_dest      = drain ? grant_q : '0;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;
endmodule
